core_fetch_queue: RTL and testbench
===================================

CORE_FETCH_QUEUE -- requirements
Module: core_fetch_queue

Interface
REQ-001 SHALL have parameter FETCH_W, default 2, meaning memory read lanes per fetch group (1..4).
REQ-002 SHALL have parameter DEPTH, default 8, meaning queue entries, a power of two and at least FETCH_W.
REQ-003 SHALL have parameters ADDR_W, default 8, and DATA_W, default 16, meaning PC/address and instruction widths.
REQ-004 SHALL have parameter RESET_PC, default 8'h10, meaning the PC loaded at reset.
REQ-005 SHALL have a single clock; reset is synchronous and active-high.
REQ-006 clk_i  in  1  clock; all state updates on rising edge.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 exec_i  in  2  0 = no new groups, 1 = run (FETCH_W lanes), 2 = single-lane step, 3 = same as 0.
REQ-009 redir_val_i / redir_pc_i  in  1 / ADDR_W  flush and restart fetch at redir_pc_i (jump, self-modify kill, manual PC write).
REQ-010 mem_val_o / mem_addr_o  out  FETCH_W / FETCH_W x ADDR_W  per-lane read request and address.
REQ-011 mem_rdy_i / mem_rdata_i  in  FETCH_W / FETCH_W x DATA_W  per-lane grant; rdata valid in the same cycle as val&&rdy.
REQ-012 deq_val_o, deq_pc_o, deq_instr_o  out  FETCH_W, FETCH_W x ADDR_W, FETCH_W x DATA_W  head entries, lane 0 = oldest.
REQ-013 deq_cnt_i  in  clog2(FETCH_W+1)  entries consumed this cycle.
REQ-014 count_o, empty_o, full_o, idle_o, pc_o  out  clog2(DEPTH+1), 1, 1, 1, ADDR_W  occupancy, flags, no open group, next fetch PC.

Function
REQ-015 SHALL open a group when no group is open, exec_i is 1 or 2, redir_val_i = 0, and free slots >= group size (FETCH_W if exec_i = 1, else 1); group size is latched at open.
REQ-016 Lane i of an open group SHALL assert mem_val_o[i] with address (group PC + i) mod 2^ADDR_W until captured; uncaptured lanes beyond the group size SHALL stay at 0.
REQ-017 On mem_val_o[i] && mem_rdy_i[i], the lane SHALL capture rdata into a per-lane hold register, drop its request next cycle, and never re-request within the group.
REQ-018 A group SHALL complete in the cycle its last lane is granted; all lanes SHALL enqueue together in lane order, using same-cycle rdata for lanes granted that cycle, hold registers otherwise.
REQ-019 A group opened and fully granted in the same cycle SHALL enqueue in that cycle (one-cycle latency to deq_val_o).
REQ-020 On completion, pc_o SHALL advance by the group size mod 2^ADDR_W; PC wrap from 2^ADDR_W-1 to 0 is legal.
REQ-021 An open group SHALL keep completing after exec_i drops to 0; only new group opens are blocked.
REQ-022 deq_val_o[k] SHALL be 1 iff count_o > k; deq_cnt_i > count_o is illegal (assertion), and deq_cnt_i entries SHALL be popped at the edge.
REQ-023 Enqueue and dequeue in the same cycle SHALL both apply; count_o next = count + enq - deq.
REQ-024 redir_val_i SHALL, at the edge, empty the queue, discard any open group and hold registers, drop all mem_val_o the next cycle, and set pc_o = redir_pc_i; same-cycle enqueue and dequeue SHALL be ignored.
REQ-025 While redir_val_i = 1, mem_val_o SHALL be 0 combinationally.
REQ-026 full_o = (count_o == DEPTH); empty_o = (count_o == 0); idle_o = no open group.

Reset
REQ-027 On rst_i: queue empty, count_o = 0, empty_o = 1, full_o = 0, idle_o = 1, pc_o = RESET_PC, mem_val_o = 0, deq_val_o = 0, hold registers cleared.
REQ-028 Reset SHALL override redirect and any open group in the same cycle.

Structure
REQ-029 The exec_i mode encoding (typedef), RESET_PC, and the queue-entry struct {pc, instr} SHALL live in the shared core package.
REQ-030 The queue storage SHALL be one sub-module, core_fetch_fifo: multi-enqueue/multi-dequeue circular buffer, power-of-two wrap, no bypass.

Verification
REQ-031 Reset, exec_i = 1, FETCH_W = 2, all rdy = 1 -> addresses 0x10/0x11 on the first cycle; deq_pc_o = {0x10, 0x11} next cycle; pc_o = 0x12.
REQ-032 Lane 1 rdy delayed 3 cycles -> lane 0 requested once, lane 1 held for 3 cycles; both enqueue together in order; no duplicate entry.
REQ-033 deq_cnt_i = 0 until full (8 entries) -> no group opens, mem_val_o = 0, full_o = 1; deq_cnt_i = 2 -> group reopens next cycle.
REQ-034 redir_val_i with redir_pc_i = 0x40 mid-group with lane 0 captured -> queue empty, capture discarded, next addresses 0x40/0x41.
REQ-035 exec_i = 2 from pc 0xFF -> single lane at 0xFF, then 0x00 (wrap); mem_val_o[1] stays 0.
REQ-036 rst_i asserted during a stalled group with 5 queued entries -> all REQ-027 values in the following cycle.

Source files
------------

// File: rtl/core_fetch_queue_pkg.sv
// Shared fetch-queue types: exec mode encoding, reset PC and the queue entry layout.
package core_fetch_queue_pkg;

    typedef enum logic [1:0] {
        EXEC_NONE     = 2'd0,
        EXEC_RUN      = 2'd1,
        EXEC_STEP     = 2'd2,
        EXEC_NONE_ALT = 2'd3
    } exec_mode_e;

    localparam logic [7:0] RESET_PC = 8'h10;

    localparam int ENTRY_ADDR_W = 8;
    localparam int ENTRY_DATA_W = 16;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] pc;
        logic [ENTRY_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/core_fetch_fifo.sv
// Multi-enqueue/multi-dequeue circular buffer; writes become visible one cycle later (no bypass).
// Caller never enqueues beyond free space or dequeues beyond count; flush empties in one edge.
module core_fetch_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 8,
    parameter int N     = 2,
    localparam int CW   = $clog2(N + 1),
    localparam int NW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic [CW-1:0]   enq_cnt_i,
    input  logic [N*W-1:0]  enq_dat_i,
    input  logic [CW-1:0]   deq_cnt_i,
    output logic [N*W-1:0]  head_dat_o,
    output logic [NW-1:0]   count_o
);
    localparam int SLOTS = 1 << PW;

    logic [W-1:0]  mem_q [SLOTS];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [NW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (CW'(i) < enq_cnt_i) begin
                    mem_q[wr_q + PW'(i)] <= enq_dat_i[i*W +: W];
                end
            end
            wr_q  <= wr_q + PW'(enq_cnt_i);
            rd_q  <= rd_q + PW'(deq_cnt_i);
            cnt_q <= cnt_q + NW'(enq_cnt_i) - NW'(deq_cnt_i);
        end
    end

    always_comb begin
        head_dat_o = '0;
        for (int k = 0; k < N; k++) begin
            head_dat_o[k*W +: W] = mem_q[rd_q + PW'(k)];
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/core_fetch_queue.sv
// Instruction fetch queue: issues per-lane reads for a fetch group, enqueues the group atomically.
// Latency: one cycle from final grant to deq_val_o; groups only open when the queue has room.
module core_fetch_queue
    import core_fetch_queue_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(core_fetch_queue_pkg::RESET_PC),
    localparam int CW     = $clog2(FETCH_W + 1),
    localparam int NW     = $clog2(DEPTH + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [1:0]                exec_i,
    input  logic                      redir_val_i,
    input  logic [ADDR_W-1:0]         redir_pc_i,
    output logic [FETCH_W-1:0]        mem_val_o,
    output logic [FETCH_W*ADDR_W-1:0] mem_addr_o,
    input  logic [FETCH_W-1:0]        mem_rdy_i,
    input  logic [FETCH_W*DATA_W-1:0] mem_rdata_i,
    output logic [FETCH_W-1:0]        deq_val_o,
    output logic [FETCH_W*ADDR_W-1:0] deq_pc_o,
    output logic [FETCH_W*DATA_W-1:0] deq_instr_o,
    input  logic [CW-1:0]             deq_cnt_i,
    output logic [NW-1:0]             count_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      idle_o,
    output logic [ADDR_W-1:0]         pc_o
);
    localparam int EW = ADDR_W + DATA_W;

    exec_mode_e          exec_mode;
    logic                grp_open_q;
    logic [CW-1:0]       grp_size_q;
    logic [FETCH_W-1:0]  captured_q;
    logic [DATA_W-1:0]   hold_q [FETCH_W];
    logic [ADDR_W-1:0]   pc_q;
    logic [NW-1:0]       count;

    logic                fetch_ok, want_open, open_now, active, complete;
    logic [CW-1:0]       size_req, cur_size, enq_cnt;
    logic [FETCH_W-1:0]  grant, in_grp;
    logic [FETCH_W*EW-1:0] enq_dat, head_dat;

    assign exec_mode = exec_mode_e'(exec_i);

    always_comb begin
        fetch_ok   = !rst_i && !redir_val_i;
        size_req   = (exec_mode == EXEC_RUN) ? CW'(FETCH_W) : CW'(1);
        want_open  = (exec_mode == EXEC_RUN) || (exec_mode == EXEC_STEP);
        open_now   = !grp_open_q && want_open && fetch_ok &&
                     ((NW'(DEPTH) - count) >= NW'(size_req));
        active     = (grp_open_q || open_now) && fetch_ok;
        cur_size   = grp_open_q ? grp_size_q : size_req;
        complete   = active;
        mem_val_o  = '0;
        mem_addr_o = '0;
        grant      = '0;
        in_grp     = '0;
        enq_dat    = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            in_grp[i]    = CW'(i) < cur_size;
            mem_val_o[i] = active && in_grp[i] && !captured_q[i];
            grant[i]     = mem_val_o[i] && mem_rdy_i[i];
            // A lane still owed data holds the whole group back.
            if (in_grp[i] && !(captured_q[i] || grant[i])) begin
                complete = 1'b0;
            end
            mem_addr_o[i*ADDR_W +: ADDR_W] = pc_q + ADDR_W'(i);
            enq_dat[i*EW +: EW] = {pc_q + ADDR_W'(i),
                                   grant[i] ? mem_rdata_i[i*DATA_W +: DATA_W] : hold_q[i]};
        end
        enq_cnt = complete ? cur_size : '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grp_open_q <= 1'b0;
            grp_size_q <= '0;
            captured_q <= '0;
            pc_q       <= RESET_PC;
            for (int i = 0; i < FETCH_W; i++) hold_q[i] <= '0;
        end else if (redir_val_i) begin
            grp_open_q <= 1'b0;
            captured_q <= '0;
            pc_q       <= redir_pc_i;
            for (int i = 0; i < FETCH_W; i++) hold_q[i] <= '0;
        end else if (complete) begin
            grp_open_q <= 1'b0;
            captured_q <= '0;
            pc_q       <= pc_q + ADDR_W'(cur_size);
        end else if (active) begin
            grp_open_q <= 1'b1;
            grp_size_q <= cur_size;
            captured_q <= captured_q | grant;
            for (int i = 0; i < FETCH_W; i++) begin
                if (grant[i]) hold_q[i] <= mem_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    core_fetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH),
        .N     (FETCH_W)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (redir_val_i),
        .enq_cnt_i  (enq_cnt),
        .enq_dat_i  (enq_dat),
        .deq_cnt_i  (deq_cnt_i),
        .head_dat_o (head_dat),
        .count_o    (count)
    );

    always_comb begin
        deq_val_o   = '0;
        deq_pc_o    = '0;
        deq_instr_o = '0;
        for (int k = 0; k < FETCH_W; k++) begin
            deq_val_o[k]                    = count > NW'(k);
            deq_pc_o[k*ADDR_W +: ADDR_W]    = head_dat[k*EW + DATA_W +: ADDR_W];
            deq_instr_o[k*DATA_W +: DATA_W] = head_dat[k*EW +: DATA_W];
        end
    end

    assign count_o = count;
    assign empty_o = (count == '0);
    assign full_o  = (count == NW'(DEPTH));
    assign idle_o  = !grp_open_q;
    assign pc_o    = pc_q;

    a_deq_le_count: assert property (@(posedge clk_i) disable iff (rst_i || redir_val_i)
                                     NW'(deq_cnt_i) <= count);

endmodule

// File: tb/tb_core_fetch_queue.sv
// Directed table-driven bench for core_fetch_queue at default parameters (FETCH_W=2, DEPTH=8).
module tb_core_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  exec;
    logic        redir;
    logic [7:0]  redir_pc;
    logic [1:0]  mem_val;
    logic [15:0] mem_addr;
    logic [1:0]  mem_rdy;
    logic [31:0] mem_rdata;
    logic [1:0]  deq_val;
    logic [15:0] deq_pc;
    logic [31:0] deq_instr;
    logic [1:0]  deq_cnt;
    logic [3:0]  count;
    logic        empty, full, idle;
    logic [7:0]  pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_fetch_queue dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .exec_i      (exec),
        .redir_val_i (redir),
        .redir_pc_i  (redir_pc),
        .mem_val_o   (mem_val),
        .mem_addr_o  (mem_addr),
        .mem_rdy_i   (mem_rdy),
        .mem_rdata_i (mem_rdata),
        .deq_val_o   (deq_val),
        .deq_pc_o    (deq_pc),
        .deq_instr_o (deq_instr),
        .deq_cnt_i   (deq_cnt),
        .count_o     (count),
        .empty_o     (empty),
        .full_o      (full),
        .idle_o      (idle),
        .pc_o        (pc)
    );

    // Memory returns C0_<addr> only on a grant, garbage otherwise.
    always_comb begin
        mem_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            mem_rdata[i*16 +: 16] = (mem_val[i] && mem_rdy[i]) ? {8'hC0, mem_addr[i*8 +: 8]} : 16'hDEAD;
        end
    end

    typedef struct {
        logic       rst;
        logic [1:0] exec;
        logic       redir;
        logic [7:0] rpc;
        logic [1:0] rdy;
        logic [1:0] deq;
        logic [1:0] mval;
        logic [7:0] a0, a1;
        logic [1:0] dval;
        logic [7:0] d0, d1;
        logic [3:0] cnt;
        logic [7:0] pc;
        logic       idle, full, empty;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [1:0] ex, input logic rd, input logic [7:0] rp,
                       input logic [1:0] rdy, input logic [1:0] dq,
                       input logic [1:0] mv, input logic [7:0] a0, input logic [7:0] a1,
                       input logic [1:0] dv, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [3:0] cn, input logic [7:0] p,
                       input logic id, input logic fu, input logic em);
        vec_t v;
        v.rst = r; v.exec = ex; v.redir = rd; v.rpc = rp; v.rdy = rdy; v.deq = dq;
        v.mval = mv; v.a0 = a0; v.a1 = a1; v.dval = dv; v.d0 = d0; v.d1 = d1;
        v.cnt = cn; v.pc = p; v.idle = id; v.full = fu; v.empty = em;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        int waited;
        //   rst ex rd rpc    rdy dq  mv a0     a1     dv d0     d1     cnt pc     id fu em
        add(1, 0, 0, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h10, 1, 0, 1); // 0 reset
        add(0, 1, 0, 8'h00, 3, 0,  3, 8'h10, 8'h11, 0, 8'h00, 8'h00, 0, 8'h10, 1, 0, 1); // 1 run, all rdy
        add(0, 0, 0, 8'h00, 3, 0,  0, 8'h00, 8'h00, 3, 8'h10, 8'h11, 2, 8'h12, 1, 0, 0);
        add(0, 0, 0, 8'h00, 3, 2,  0, 8'h00, 8'h00, 3, 8'h10, 8'h11, 2, 8'h12, 1, 0, 0); // pop 2
        add(0, 0, 0, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h12, 1, 0, 1);
        add(0, 1, 0, 8'h00, 1, 0,  3, 8'h12, 8'h13, 0, 8'h00, 8'h00, 0, 8'h12, 1, 0, 1); // 5 lane1 stalls
        add(0, 0, 0, 8'h00, 1, 0,  2, 8'h00, 8'h13, 0, 8'h00, 8'h00, 0, 8'h12, 0, 0, 1);
        add(0, 0, 0, 8'h00, 0, 0,  2, 8'h00, 8'h13, 0, 8'h00, 8'h00, 0, 8'h12, 0, 0, 1);
        add(0, 0, 0, 8'h00, 2, 0,  2, 8'h00, 8'h13, 0, 8'h00, 8'h00, 0, 8'h12, 0, 0, 1);
        add(0, 0, 0, 8'h00, 0, 0,  0, 8'h00, 8'h00, 3, 8'h12, 8'h13, 2, 8'h14, 1, 0, 0);
        add(0, 1, 0, 8'h00, 3, 0,  3, 8'h14, 8'h15, 3, 8'h12, 8'h13, 2, 8'h14, 1, 0, 0); // 10 fill
        add(0, 1, 0, 8'h00, 3, 0,  3, 8'h16, 8'h17, 3, 8'h12, 8'h13, 4, 8'h16, 1, 0, 0);
        add(0, 1, 0, 8'h00, 3, 0,  3, 8'h18, 8'h19, 3, 8'h12, 8'h13, 6, 8'h18, 1, 0, 0);
        add(0, 1, 0, 8'h00, 3, 0,  0, 8'h00, 8'h00, 3, 8'h12, 8'h13, 8, 8'h1A, 1, 1, 0); // full
        add(0, 1, 0, 8'h00, 3, 2,  0, 8'h00, 8'h00, 3, 8'h12, 8'h13, 8, 8'h1A, 1, 1, 0);
        add(0, 1, 0, 8'h00, 3, 0,  3, 8'h1A, 8'h1B, 3, 8'h14, 8'h15, 6, 8'h1A, 1, 0, 0); // 15 reopens
        add(0, 0, 0, 8'h00, 0, 2,  0, 8'h00, 8'h00, 3, 8'h14, 8'h15, 8, 8'h1C, 1, 1, 0);
        add(0, 1, 0, 8'h00, 1, 0,  3, 8'h1C, 8'h1D, 3, 8'h16, 8'h17, 6, 8'h1C, 1, 0, 0); // lane0 captured
        add(0, 0, 1, 8'h40, 3, 0,  0, 8'h00, 8'h00, 3, 8'h16, 8'h17, 6, 8'h1C, 0, 0, 0); // redirect
        add(0, 1, 0, 8'h00, 2, 0,  3, 8'h40, 8'h41, 0, 8'h00, 8'h00, 0, 8'h40, 1, 0, 1);
        add(0, 0, 0, 8'h00, 1, 0,  1, 8'h40, 8'h00, 0, 8'h00, 8'h00, 0, 8'h40, 0, 0, 1); // 20
        add(0, 0, 0, 8'h00, 0, 0,  0, 8'h00, 8'h00, 3, 8'h40, 8'h41, 2, 8'h42, 1, 0, 0);
        add(0, 0, 1, 8'hFF, 0, 0,  0, 8'h00, 8'h00, 3, 8'h40, 8'h41, 2, 8'h42, 1, 0, 0);
        add(0, 2, 0, 8'h00, 3, 0,  1, 8'hFF, 8'h00, 0, 8'h00, 8'h00, 0, 8'hFF, 1, 0, 1); // step at FF
        add(0, 2, 0, 8'h00, 3, 1,  1, 8'h00, 8'h00, 1, 8'hFF, 8'h00, 1, 8'h00, 1, 0, 0); // wrap, enq+deq
        add(0, 0, 0, 8'h00, 0, 0,  0, 8'h00, 8'h00, 1, 8'h00, 8'h00, 1, 8'h01, 1, 0, 0); // 25
        add(0, 1, 0, 8'h00, 3, 0,  3, 8'h01, 8'h02, 1, 8'h00, 8'h00, 1, 8'h01, 1, 0, 0);
        add(0, 1, 0, 8'h00, 3, 0,  3, 8'h03, 8'h04, 3, 8'h00, 8'h01, 3, 8'h03, 1, 0, 0);
        add(0, 1, 0, 8'h00, 0, 0,  3, 8'h05, 8'h06, 3, 8'h00, 8'h01, 5, 8'h05, 1, 0, 0); // stalls
        add(0, 0, 0, 8'h00, 0, 0,  3, 8'h05, 8'h06, 3, 8'h00, 8'h01, 5, 8'h05, 0, 0, 0);
        add(1, 1, 1, 8'h77, 1, 0,  0, 8'h00, 8'h00, 3, 8'h00, 8'h01, 5, 8'h05, 0, 0, 0); // 30 reset+redir
        add(0, 0, 0, 8'h00, 0, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h10, 1, 0, 1);
        add(0, 3, 0, 8'h00, 3, 0,  0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0, 8'h10, 1, 0, 1); // exec=3 idle

        rst = 1'b1; exec = 2'd0; redir = 1'b0; redir_pc = 8'h00; mem_rdy = 2'b00; deq_cnt = 2'd0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < vecs.size(); v++) begin
            @(negedge clk);
            rst = vecs[v].rst; exec = vecs[v].exec; redir = vecs[v].redir;
            redir_pc = vecs[v].rpc; mem_rdy = vecs[v].rdy; deq_cnt = vecs[v].deq;
            #1;
            check($sformatf("v%0d mem_val", v), 32'(mem_val), 32'(vecs[v].mval));
            if (vecs[v].mval[0]) check($sformatf("v%0d addr0", v), 32'(mem_addr[7:0]), 32'(vecs[v].a0));
            if (vecs[v].mval[1]) check($sformatf("v%0d addr1", v), 32'(mem_addr[15:8]), 32'(vecs[v].a1));
            check($sformatf("v%0d deq_val", v), 32'(deq_val), 32'(vecs[v].dval));
            if (vecs[v].dval[0]) begin
                check($sformatf("v%0d deq_pc0", v), 32'(deq_pc[7:0]), 32'(vecs[v].d0));
                check($sformatf("v%0d deq_instr0", v), 32'(deq_instr[15:0]), {16'h0, 8'hC0, vecs[v].d0});
            end
            if (vecs[v].dval[1]) begin
                check($sformatf("v%0d deq_pc1", v), 32'(deq_pc[15:8]), 32'(vecs[v].d1));
                check($sformatf("v%0d deq_instr1", v), 32'(deq_instr[31:16]), {16'h0, 8'hC0, vecs[v].d1});
            end
            check($sformatf("v%0d count", v), 32'(count), 32'(vecs[v].cnt));
            check($sformatf("v%0d pc", v), 32'(pc), 32'(vecs[v].pc));
            check($sformatf("v%0d idle", v), 32'(idle), 32'(vecs[v].idle));
            check($sformatf("v%0d full", v), 32'(full), 32'(vecs[v].full));
            check($sformatf("v%0d empty", v), 32'(empty), 32'(vecs[v].empty));
        end

        // Fresh run group from the reset PC, waiting a bounded time for the head to appear.
        @(negedge clk);
        exec = 2'd1; mem_rdy = 2'b11; deq_cnt = 2'd0;
        @(negedge clk);
        exec = 2'd0;
        #1;
        waited = 0;
        while (!deq_val[0] && waited < 4) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("seq head arrives", 32'(deq_val[0]), 32'd1);
        check("seq latency", 32'(waited), 32'd0);
        check("seq deq_pc0", 32'(deq_pc[7:0]), 32'h10);
        check("seq deq_pc1", 32'(deq_pc[15:8]), 32'h11);
        check("seq instr1", 32'(deq_instr[31:16]), 32'hC011);
        check("seq pc", 32'(pc), 32'h12);
        check("seq count", 32'(count), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
